// File: rtl/alu_accum_pkg.sv
// Shared types for the registered accumulator ALU: function codes and FSM states.
package alu_accum_pkg;

    localparam int unsigned FN_W = 3;

    typedef enum logic [FN_W-1:0] {
        FN_ADD  = 3'b000,
        FN_MUL  = 3'b001,
        FN_SHL  = 3'b010,
        FN_SHR  = 3'b011,
        FN_OR   = 3'b100,
        FN_AND  = 3'b101,
        FN_CAT  = 3'b110,
        FN_HOLD = 3'b111
    } fn_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps per load.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;
    logic [PW-1:0]    step_sum;

    // Accumulator after the step performed this cycle; on the last step this is the full product.
    always_comb begin
        step_sum = acc + (mplier[0] ? mcand : '0);
    end

    assign product = step_sum;
    assign last    = (count == CW'(WIDTH - 1));

    // count == WIDTH marks the datapath as parked until the next load.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= CW'(WIDTH);
        end else if (load) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (count != CW'(WIDTH)) begin
            acc    <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_accum_reg.sv
// Registered accumulator ALU: operand B feeds back from ALUout, multiply is sequential.
// Optional Zero output is enabled with `define ALU_ZERO_FLAG_EN.
module alu_accum_reg
    import alu_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     Data,
    input  logic [FN_W-1:0]      Function,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
`ifdef ALU_ZERO_FLAG_EN
    output logic                 Zero,
`endif
    output logic [2*WIDTH-1:0]   ALUout
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    fn_t              fn;
    logic [WIDTH-1:0] op_b;
    logic [PW-1:0]    op_result;
    logic [PW-1:0]    alu_next;
    logic             done_next;
    logic             busy_next;
    logic             mul_load;
    logic [PW-1:0]    product;
    logic             last;

    assign fn   = fn_t'(Function);
    assign op_b = ALUout[WIDTH-1:0];

    // Single-cycle results, all zero-extended to the full register width.
    always_comb begin
        op_result = ALUout;
        case (fn)
            FN_ADD:  op_result = PW'(Data) + PW'(op_b);
            FN_MUL:  op_result = ALUout;
            FN_SHL:  op_result = (32'(Data) >= PW) ? '0 : (PW'(op_b) << Data);
            FN_SHR:  op_result = (32'(Data) >= PW) ? '0 : (PW'(op_b) >> Data);
            FN_OR:   op_result = PW'((|Data) | (|op_b));
            FN_AND:  op_result = PW'((&Data) & (&op_b));
            FN_CAT:  op_result = {Data, op_b};
            FN_HOLD: op_result = ALUout;
            default: op_result = ALUout;
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (mul_load),
        .a       (Data),
        .b       (op_b),
        .product (product),
        .last    (last)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_next = state;
        alu_next   = ALUout;
        done_next  = 1'b0;
        mul_load   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (fn == FN_MUL) begin
                        state_next = MUL;
                        mul_load   = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        alu_next  = op_result;
                    end
                end
            end
            MUL: begin
                if (last) begin
                    state_next = IDLE;
                    alu_next   = product;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == MUL);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            ALUout <= '0;
            Done   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_next;
            ALUout <= alu_next;
            Done   <= done_next;
            Busy   <= busy_next;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Zero tracks ALUout exactly; holds and multiply cycles keep ALUout, hence Zero, unchanged.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Zero <= 1'b1;
        end else begin
            Zero <= (alu_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_accum_reg.sv
// Self-checking bench for alu_accum_reg: directed test-plan sequences plus random ops vs a cycle model.
module tb_alu_accum_reg;
    import alu_accum_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned MASK = (1 << PW) - 1;

    logic            clk;
    logic            Reset;
    logic [W-1:0]    Data;
    logic [2:0]      Function;
    logic            Start;
    logic            Busy;
    logic            Done;
    logic [PW-1:0]   ALUout;
`ifdef ALU_ZERO_FLAG_EN
    logic            Zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_alu;
    int unsigned m_pend;
    int          m_busy_cnt;
    bit          m_done;
    bit          m_zero;

    alu_accum_reg #(.WIDTH(W)) dut (
        .Clock    (clk),
        .Reset    (Reset),
        .Data     (Data),
        .Function (Function),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
`ifdef ALU_ZERO_FLAG_EN
        .Zero     (Zero),
`endif
        .ALUout   (ALUout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model the effect of one rising edge from the architectural rules.
    task automatic model_edge(input bit rst, input bit st, input int unsigned fn, input int unsigned a);
        int unsigned b;
        b = m_alu % (1 << W);
        m_done = 1'b0;
        if (rst) begin
            m_alu = 0; m_busy_cnt = 0; m_zero = 1'b1;
        end else if (m_busy_cnt > 0) begin
            m_busy_cnt--;
            if (m_busy_cnt == 0) begin
                m_alu  = m_pend;
                m_zero = (m_alu == 0);
                m_done = 1'b1;
            end
        end else if (st) begin
            m_done = 1'b1;
            case (fn)
                0: m_alu = a + b;
                1: begin m_pend = a * b; m_busy_cnt = W; m_done = 1'b0; end
                2: m_alu = (a >= PW) ? 0 : ((b << a) & MASK);
                3: m_alu = (a >= PW) ? 0 : (b >> a);
                4: m_alu = (a != 0 || b != 0) ? 1 : 0;
                5: m_alu = (a == (1 << W) - 1 && b == (1 << W) - 1) ? 1 : 0;
                6: m_alu = a * (1 << W) + b;
                default: ;
            endcase
            if (fn != 1 && fn != 7) m_zero = (m_alu == 0);
        end
    endtask

    task automatic step(input bit rst, input bit st, input logic [2:0] fn, input logic [W-1:0] d);
        @(negedge clk);
        Reset = rst; Start = st; Function = fn; Data = d;
        @(posedge clk);
        #1;
        model_edge(rst, st, int'(fn), int'(d));
        check_eq("alu", 32'(ALUout), m_alu);
        check_eq("busy", 32'(Busy), 32'(m_busy_cnt > 0));
        check_eq("done", 32'(Done), 32'(m_done));
`ifdef ALU_ZERO_FLAG_EN
        check_eq("zero", 32'(Zero), 32'(m_zero));
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom_range(0, 7), W'($urandom));
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; Function = '0; Data = '0;
        m_alu = 0; m_pend = 0; m_busy_cnt = 0; m_done = 0; m_zero = 1;

        // Reset, then add chain
        step(1, 0, FN_ADD, 0);
        step(1, 0, FN_ADD, 0);
        check_eq("reset_alu", 32'(ALUout), 32'h00);
        check_eq("reset_done", 32'(Done), 0);
`ifdef ALU_ZERO_FLAG_EN
        check_eq("reset_zero", 32'(Zero), 1);
`endif
        step(0, 1, FN_ADD, 4'h3);
        check_eq("add3", 32'(ALUout), 32'h03);
        check_eq("add3_done", 32'(Done), 1);
        idle();
        check_eq("done_single", 32'(Done), 0);
        step(0, 1, FN_ADD, 4'h5);
        check_eq("add5", 32'(ALUout), 32'h08);
        step(0, 1, FN_ADD, 4'hF);
        check_eq("add_nowrap", 32'(ALUout), 32'h17);

        // Multiply with back-to-back start in the Done cycle
        step(1, 0, FN_ADD, 0);
        step(0, 1, FN_ADD, 4'h8);
        step(0, 1, FN_MUL, 4'hF);
        n = 0;
        while (Busy && n < 10) begin
            n++;
            check_eq("mul_hold_alu", 32'(ALUout), 32'h08);
            idle();
        end
        check_eq("mul_busy_cycles", n, 4);
        check_eq("mul_result", 32'(ALUout), 32'h78);
        check_eq("mul_done", 32'(Done), 1);
        step(0, 1, FN_SHL, 4'h2);
        check_eq("shl_b2b", 32'(ALUout), 32'h20);

        // Busy lockout, then reset abort
        step(1, 0, FN_ADD, 0);
        step(0, 1, FN_ADD, 4'h3);
        step(0, 1, FN_MUL, 4'h5);
        step(0, 1, FN_ADD, 4'h1);
        for (int i = 0; i < 4; i++) idle();
        check_eq("lockout_result", 32'(ALUout), 32'h0F);
        step(0, 1, FN_MUL, 4'h2);
        idle();
        step(1, 0, FN_ADD, 0);
        check_eq("abort_alu", 32'(ALUout), 0);
        check_eq("abort_busy", 32'(Busy), 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_eq("abort_no_done", 32'(Done), 0);
        end

        // Reductions, concat and hold from B=0
        step(1, 0, FN_ADD, 0);
        step(0, 1, FN_OR, 4'hA);
        check_eq("or_red", 32'(ALUout), 32'h01);
        step(0, 1, FN_AND, 4'hF);
        check_eq("and_red", 32'(ALUout), 32'h00);
        step(0, 1, FN_CAT, 4'hA);
        check_eq("concat", 32'(ALUout), 32'hA0);
        step(0, 1, FN_HOLD, 4'h5);
        check_eq("hold", 32'(ALUout), 32'hA0);
        check_eq("hold_done", 32'(Done), 1);

        // Shift boundaries
        step(1, 0, FN_ADD, 0);
        step(0, 1, FN_ADD, 4'h9);
        step(0, 1, FN_SHR, 4'h3);
        check_eq("shr3", 32'(ALUout), 32'h01);
        step(1, 0, FN_ADD, 0);
        step(0, 1, FN_ADD, 4'h9);
        step(0, 1, FN_SHL, 4'h8);
        check_eq("shl_oob", 32'(ALUout), 32'h00);
`ifdef ALU_ZERO_FLAG_EN
        check_eq("shl_oob_zero", 32'(Zero), 1);
`endif

        // Random ops against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 60) == 0, ($urandom % 3) != 0,
                 3'($urandom_range(0, 7)), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_accum_reg.md
Name: alu_accum_reg

Overview:
- Parametrised, registered successor to the combinational 4-bit lab ALU.
- Operand A comes from the Data input. Operand B is fed back from the low WIDTH bits of the output register, in accumulator style.
- Single-cycle ops: add, shifts, reductions, concat and hold. Multiply is a multi-cycle shift-add.
- A Start/Busy/Done handshake sequences the ops; sits between lab switch/key inputs and the LED/HEX display logic.

Parameters:
- WIDTH, 4, operand width in bits (>=2); the result register is 2*WIDTH bits.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Data  input  WIDTH  operand A; sampled only on the cycle Start is accepted.
- Function  input  3  operation code; sampled with Data.
- Start  input  1  request; accepted only when state is IDLE.
- Busy  output  1  high while a multiply is in progress.
- Done  output  1  one-cycle pulse, the cycle after ALUout is written.
- ALUout  output  2*WIDTH  result register.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - ALUout=0, Done=0, Busy=0, state=IDLE.
  - Aborts any multiply in flight; the partial product is discarded.
- B = ALUout[WIDTH-1:0], captured at Start acceptance.
- All results are zero-extended to 2*WIDTH bits; no operation wraps inside WIDTH bits.
- Function codes:
  - 000 add: A+B; carry lands in bit WIDTH.
  - 001 mul: A*B, unsigned.
  - 010 shl: {0,B} << A; result 0 if A >= 2*WIDTH.
  - 011 shr: {0,B} >> A; result 0 if A >= 2*WIDTH.
  - 100 or-reduce: result = (|A | |B) in bit 0; upper bits 0.
  - 101 and-reduce: result = (&A & &B) in bit 0; upper bits 0.
  - 110 concat: result = {A,B}.
  - 111 hold: ALUout unchanged; still pulses Done.
- FSM states: IDLE, MUL.
  - IDLE with Start=1 and a non-mul code, in cycle t: ALUout is loaded at the end of t; Done=1 during t+1; state stays IDLE.
  - IDLE with Start=1 and code 001, in cycle t: go to MUL, load the multiplicand/multiplier registers, clear the internal product; Busy=1 during t+1 .. t+WIDTH.
  - MUL: one shift-add step per cycle, WIDTH steps. At the end of cycle t+WIDTH, ALUout = product and state -> IDLE. Busy=0 and Done=1 during t+WIDTH+1.
- ALUout holds its previous value throughout the multiply; partial products are never visible.
- Start while Busy=1 is ignored (no queueing; Data/Function are not sampled).
- Start during the Done cycle is accepted, giving back-to-back ops at one per cycle.
- Done is never high for two consecutive cycles unless a new op was accepted in the intervening cycle.
- Data/Function changes while not accepted have no effect.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- Defined: adds output port Zero (1 bit), registered and updated whenever ALUout is written.
  - Zero=1 iff the newly written value is all zeros.
  - Reset value 1.
  - A hold op leaves Zero unchanged.
- Undefined: no Zero port, no extra logic; all other behaviour identical.

Decomposition:
- Package alu_accum_pkg:
  - Function-code enum fn_t: FN_ADD, FN_MUL, FN_SHL, FN_SHR, FN_OR, FN_AND, FN_CAT, FN_HOLD.
  - FSM enum state_t: IDLE, MUL.
- Sub-module alu_mul_seq #(WIDTH):
  - Inputs: Clock, Reset, load, a, b.
  - Outputs: product, last.
  - Contains the step counter and the shift-add datapath.
  - The top-level FSM uses last to exit MUL.

Test Plan (WIDTH=4):
- Reset, then add chain: after Reset, ALUout=0x00, Zero=1. Start add Data=0x3 -> ALUout=0x03, Done pulse. Start add Data=0x5 -> 0x08. Start add Data=0xF -> 0x17 (no wrap).
- Multiply with back-to-back start: load 0x08 (e.g. concat Data=0x0 after B=8), then start mul Data=0xF.
  - Busy high for exactly 4 cycles; ALUout stays 0x08 during them.
  - ALUout then reads 0x78 and Done pulses once.
  - Start shl Data=0x2 in the Done cycle -> ALUout=0x20 next cycle.
- Busy lockout and reset abort: start mul; pulse Start with add Data=0x1 during Busy -> ignored, product unaffected. Start another mul and assert Reset at the 2nd Busy cycle -> ALUout=0, Busy=0, no Done.
- Reductions and concat from B=0:
  - or-reduce Data=0xA -> 0x01.
  - and-reduce Data=0xF, B=1 -> 0x00.
  - concat Data=0xA, B=0 -> 0xA0.
  - hold -> ALUout unchanged, Done pulse.
- Shift boundaries: B=0x9, shr Data=0x3 -> 0x01. Reload B=0x9, shl Data=0x8 -> 0x00, and Zero=1 when ALU_ZERO_FLAG_EN is defined.
